datapath_seq: RTL and testbench



---
 rtl/datapath_seq_if.sv | 34 +++
 rtl/datapath_seq.sv | 212 +++++++++++++++++++++
 tb/tb_datapath_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
// rtl/datapath_seq_if.sv - command, register-port and status bundle for datapath_seq
interface datapath_seq_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic             start;
  logic [3:0]       op;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [AW-1:0]    rc;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, ra, rb, rc, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, done, illegal, div_zero, hi, lo
  );

  modport slave (
    input  start, op, ra, rb, rc, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, done, illegal, div_zero, hi, lo
  );
endinterface

// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - single-bus register-file datapath with ALU, shift-add MUL and restoring DIV
module datapath_seq #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input logic           clk,
  input logic           clr,
  datapath_seq_if.slave cpu
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  typedef enum logic [2:0] {IDLE, LDY, EXEC, ITER, WB} state_t;

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] zhi;
  logic [WIDTH-1:0] zlo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] it_a;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [AW-1:0]    ra_q;
  logic [AW-1:0]    rb_q;
  logic [AW-1:0]    rc_q;
  logic             dz_q;
  logic             done_q;
  logic             ill_q;
  logic             dz_out_q;

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu;
  logic [SW-1:0]    sh;
  logic             is_muldiv;
  logic             is_div;
  logic             is_ill;
  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi_nx;
  logic [WIDTH-1:0] it_lo_nx;

  assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign is_div    = (op_q == OP_DIV);
  assign is_ill    = (op_q[3] && op_q[2]);
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign sh        = bus[SW-1:0];

  assign cpu.rd_data  = regs[cpu.rd_addr];
  assign cpu.busy     = (state != IDLE);
  assign cpu.done     = done_q;
  assign cpu.illegal  = ill_q;
  assign cpu.div_zero = dz_out_q;
  assign cpu.hi       = hi_q;
  assign cpu.lo       = lo_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cpu.start) state_nx = LDY;
      LDY:     state_nx = EXEC;
      EXEC:    state_nx = is_muldiv ? ITER : WB;
      ITER:    if (last_iter) state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The one shared bus: operand A, operand B, then the result on its way back.
  always_comb begin
    bus = '0;
    case (state)
      LDY:     bus = regs[ra_q];
      EXEC:    bus = regs[rb_q];
      WB:      bus = zlo;
      default: bus = '0;
    endcase
  end

  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = y + bus;
      OP_SUB:  alu = y - bus;
      OP_AND:  alu = y & bus;
      OP_OR:   alu = y | bus;
      OP_SHR:  alu = y >> sh;
      OP_SHL:  alu = y << sh;
      OP_ROR:  alu = (y >> sh) | (y << (WIDTH - int'(sh)));
      OP_ROL:  alu = (y << sh) | (y >> (WIDTH - int'(sh)));
      OP_NEG:  alu = {WIDTH{1'b0}} - bus;
      OP_NOT:  alu = ~bus;
      default: alu = '0;
    endcase
  end

  // MUL: {it_hi,it_lo} shifts right with it_lo as multiplier. DIV: it_lo holds
  // the dividend shifting out the top while quotient bits shift in at the bottom.
  // A zero divisor always subtracts, leaving all-ones quotient and the dividend as remainder.
  always_comb begin
    mul_sum   = {1'b0, it_hi} + (it_lo[0] ? {1'b0, it_a} : {(WIDTH+1){1'b0}});
    div_shift = {it_hi, it_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, it_a});
    div_diff  = div_shift[WIDTH-1:0] - it_a;
    if (is_div) begin
      it_hi_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
      it_lo_nx = {it_lo[WIDTH-2:0], div_ge};
    end else begin
      it_hi_nx = mul_sum[WIDTH:1];
      it_lo_nx = {mul_sum[0], it_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      y        <= '0;
      zhi      <= '0;
      zlo      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      it_a     <= '0;
      it_hi    <= '0;
      it_lo    <= '0;
      cnt      <= '0;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      dz_out_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.wr_en) regs[cpu.wr_addr] <= cpu.wr_data;
          if (cpu.start) begin
            op_q <= cpu.op;
            ra_q <= cpu.ra;
            rb_q <= cpu.rb;
            rc_q <= cpu.rc;
          end
        end
        LDY: y <= bus;
        EXEC: begin
          if (is_muldiv) begin
            it_a  <= bus;
            it_hi <= '0;
            it_lo <= y;
            cnt   <= '0;
            dz_q  <= is_div && (bus == '0);
          end else begin
            zlo <= alu;
            zhi <= '0;
          end
        end
        ITER: begin
          cnt   <= cnt + CW'(1);
          it_hi <= it_hi_nx;
          it_lo <= it_lo_nx;
          if (last_iter) begin
            zhi <= it_hi_nx;
            zlo <= it_lo_nx;
          end
        end
        WB: begin
          if (op_q < OP_MUL) begin
            regs[rc_q] <= bus;
          end else if (is_muldiv) begin
            hi_q <= zhi;
            lo_q <= zlo;
          end
          done_q   <= 1'b1;
          ill_q    <= is_ill;
          dz_out_q <= dz_q && is_div;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_seq.sv
// tb/tb_datapath_seq.sv - vector table plus scoreboard bench for datapath_seq
module tb_datapath_seq;
  localparam int W = 32;
  localparam int N = 16;
  localparam logic [W-1:0] SENT = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  datapath_seq_if #(.WIDTH(W), .NREGS(N)) dif ();
  datapath_seq #(.WIDTH(W), .NREGS(N)) dut (.clk(clk), .clr(clr), .cpu(dif));

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] rd;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    bit           hl;
    bit           ill;
    bit           dz;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[18];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] rd, input logic [W-1:0] hi, input logic [W-1:0] lo,
                              input int lat, input bit hl, input bit ill, input bit dz);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.hi = hi; v.lo = lo;
    v.lat = lat; v.hl = hl; v.ill = ill; v.dz = dz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    dif.wr_en = 1'b1; dif.wr_addr = a; dif.wr_data = d;
    tick();
    dif.wr_en = 1'b0;
  endtask

  task automatic launch(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input vec_t e);
    sb.push_back(e);
    dif.start = 1'b1; dif.op = op; dif.ra = ra; dif.rb = rb; dif.rc = rc; dif.rd_addr = rc;
    tick();
    dif.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int spent);
    int   n;
    vec_t e;
    n = spent;
    while (dif.done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    if (dif.done !== 1'b1) begin
      chk({tag, "_timeout"}, 64'(dif.done), 64'd1);
      return;
    end
    chk({tag, "_lat"}, 64'(n), 64'(e.lat));
    chk({tag, "_busy"}, 64'(dif.busy), 64'd0);
    chk({tag, "_ill"}, 64'(dif.illegal), 64'(e.ill));
    chk({tag, "_dz"}, 64'(dif.div_zero), 64'(e.dz));
    chk({tag, "_rd"}, 64'(dif.rd_data), 64'(e.rd));
    if (e.hl) begin
      chk({tag, "_hi"}, 64'(dif.hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(dif.lo), 64'(e.lo));
    end
  endtask

  task automatic pulse_gone(input string tag);
    tick();
    chk({tag, "_done_1cyc"}, 64'(dif.done), 64'd0);
    chk({tag, "_ill_1cyc"}, 64'(dif.illegal), 64'd0);
    chk({tag, "_dz_1cyc"}, 64'(dif.div_zero), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(4'd0,  32'd5,          32'd7,          32'd12,         '0, '0, 3, 0, 0, 0);
    tbl[1]  = mk(4'd1,  32'd0,          32'd1,          32'hFFFF_FFFF,  '0, '0, 3, 0, 0, 0);
    tbl[2]  = mk(4'd2,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  '0, '0, 3, 0, 0, 0);
    tbl[3]  = mk(4'd3,  32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  '0, '0, 3, 0, 0, 0);
    tbl[4]  = mk(4'd4,  32'h8000_0000,  32'd31,         32'd1,          '0, '0, 3, 0, 0, 0);
    tbl[5]  = mk(4'd5,  32'd1,          32'd36,         32'h10,         '0, '0, 3, 0, 0, 0);
    tbl[6]  = mk(4'd6,  32'd1,          32'd33,         32'h8000_0000,  '0, '0, 3, 0, 0, 0);
    tbl[7]  = mk(4'd7,  32'h8000_0001,  32'd4,          32'h18,         '0, '0, 3, 0, 0, 0);
    tbl[8]  = mk(4'd8,  32'd0,          32'd1,          32'hFFFF_FFFF,  '0, '0, 3, 0, 0, 0);
    tbl[9]  = mk(4'd9,  32'd0,          32'h0F0F_0F0F,  32'hF0F0_F0F0,  '0, '0, 3, 0, 0, 0);
    tbl[10] = mk(4'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  SENT, 32'hFFFF_FFFE, 32'h1,         35, 1, 0, 0);
    tbl[11] = mk(4'd11, 32'd100,        32'd7,          SENT, 32'd2,         32'd14,        35, 1, 0, 0);
    tbl[12] = mk(4'd11, 32'd9,          32'd0,          SENT, 32'd9,         32'hFFFF_FFFF, 35, 1, 0, 1);
    tbl[13] = mk(4'd10, 32'h1234_5678,  32'h10,         SENT, 32'h1,         32'h2345_6780, 35, 1, 0, 0);
    tbl[14] = mk(4'd13, 32'd1,          32'd2,          SENT, 32'h1,         32'h2345_6780, 3,  1, 1, 0);
    tbl[15] = mk(4'd6,  32'h1234_5678,  32'h20,         32'h1234_5678,  '0, '0, 3, 0, 0, 0);
    tbl[16] = mk(4'd1,  32'd5,          32'd7,          32'hFFFF_FFFE,  '0, '0, 3, 0, 0, 0);
    tbl[17] = mk(4'd15, 32'd3,          32'd4,          SENT, 32'h1,         32'h2345_6780, 3,  1, 1, 0);

    clr = 1'b0;
    dif.start = 1'b0; dif.op = '0; dif.ra = '0; dif.rb = '0; dif.rc = '0;
    dif.wr_en = 1'b0; dif.wr_addr = '0; dif.wr_data = '0; dif.rd_addr = '0;
    tick();
    tick();
    chk("rst_busy", 64'(dif.busy), 64'd0);
    chk("rst_done", 64'(dif.done), 64'd0);
    chk("rst_hi", 64'(dif.hi), 64'd0);
    chk("rst_lo", 64'(dif.lo), 64'd0);
    for (int i = 0; i < N; i++) begin
      dif.rd_addr = 4'(i);
      #1;
      chk($sformatf("rst_r%0d", i), 64'(dif.rd_data), 64'd0);
    end
    clr = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      wr(4'd1, tbl[i].a);
      wr(4'd2, tbl[i].b);
      wr(4'd3, SENT);
      launch(tbl[i].op, 4'd1, 4'd2, 4'd3, tbl[i]);
      wait_done($sformatf("v%0d", i), 0);
      pulse_gone($sformatf("v%0d", i));
    end

    // start and wr_en while busy are both dropped
    wr(4'd1, 32'd5);
    wr(4'd2, 32'd7);
    launch(4'd0, 4'd1, 4'd2, 4'd3, mk(4'd0, 0, 0, 32'd12, '0, '0, 3, 0, 0, 0));
    dif.start = 1'b1; dif.op = 4'd1;
    dif.wr_en = 1'b1; dif.wr_addr = 4'd1; dif.wr_data = 32'd100;
    tick();
    dif.start = 1'b0; dif.wr_en = 1'b0;
    wait_done("busy_ign", 1);
    pulse_gone("busy_ign");
    chk("busy_ign_idle", 64'(dif.busy), 64'd0);
    dif.rd_addr = 4'd1;
    #1;
    chk("busy_ign_r1", 64'(dif.rd_data), 64'd5);

    // write and start on the same edge: operand sees the new value
    dif.wr_en = 1'b1; dif.wr_addr = 4'd1; dif.wr_data = 32'd20;
    launch(4'd0, 4'd1, 4'd2, 4'd3, mk(4'd0, 0, 0, 32'd27, '0, '0, 3, 0, 0, 0));
    dif.wr_en = 1'b0;
    wait_done("same_edge", 0);

    // back-to-back start in the done cycle
    launch(4'd1, 4'd3, 4'd1, 4'd4, mk(4'd1, 0, 0, 32'd7, '0, '0, 3, 0, 0, 0));
    chk("b2b_busy", 64'(dif.busy), 64'd1);
    chk("b2b_done_low", 64'(dif.done), 64'd0);
    wait_done("b2b", 0);
    pulse_gone("b2b");

    // full aliasing versus distinct equal-valued registers
    wr(4'd5, 32'd6);
    launch(4'd0, 4'd5, 4'd5, 4'd5, mk(4'd0, 0, 0, 32'd12, '0, '0, 3, 0, 0, 0));
    wait_done("alias", 0);
    pulse_gone("alias");
    wr(4'd6, 32'd6);
    wr(4'd7, 32'd6);
    launch(4'd0, 4'd6, 4'd7, 4'd8, mk(4'd0, 0, 0, 32'd12, '0, '0, 3, 0, 0, 0));
    wait_done("distinct", 0);
    pulse_gone("distinct");

    // clr in the middle of a MUL iteration
    wr(4'd1, 32'hFFFF_FFFF);
    wr(4'd2, 32'd3);
    dif.start = 1'b1; dif.op = 4'd10; dif.ra = 4'd1; dif.rb = 4'd2; dif.rc = 4'd3;
    tick();
    dif.start = 1'b0;
    tick();
    tick();
    repeat (9) tick();
    chk("mid_busy", 64'(dif.busy), 64'd1);
    chk("mid_hi_before", 64'(dif.hi), 64'd1);
    #2;
    clr = 1'b0;
    #1;
    chk("clr_busy", 64'(dif.busy), 64'd0);
    chk("clr_hi", 64'(dif.hi), 64'd0);
    chk("clr_lo", 64'(dif.lo), 64'd0);
    chk("clr_done", 64'(dif.done), 64'd0);
    for (int i = 0; i < N; i++) begin
      dif.rd_addr = 4'(i);
      #1;
      chk($sformatf("clr_r%0d", i), 64'(dif.rd_data), 64'd0);
    end
    @(negedge clk);
    clr = 1'b1;
    sb.push_back(mk(4'd0, 0, 0, 32'd0, '0, '0, 3, 0, 0, 0));
    dif.start = 1'b1; dif.op = 4'd0; dif.ra = 4'd0; dif.rb = 4'd0; dif.rc = 4'd0; dif.rd_addr = 4'd0;
    tick();
    dif.start = 1'b0;
    chk("post_clr_accept", 64'(dif.busy), 64'd1);
    wait_done("post_clr", 0);
    pulse_gone("post_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
